// File: rtl/demux1_2_8bit_stream_pkg.sv
// Shared definitions for the packet-aware 1:2 byte stream demultiplexer:
// default widths, FSM state encoding and route encoding.
package demux1_2_8bit_stream_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    // A new packet takes its route from in_sel; an open packet keeps the latched route.
    function automatic logic pick_tgt(input state_e state, input logic sel, input logic cur_sel);
        logic tgt;
        case (state)
            ST_IDLE: tgt = sel;
            ST_BUSY: tgt = cur_sel;
            default: tgt = SEL_OUT0;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/demux1_2_8bit_stream_out_stage.sv
// One-entry registered output stage: holds a data/last beat behind a valid/ready
// handshake and counts packets whose last beat is handed to the consumer.
module demux_out_stage
    import demux1_2_8bit_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic             free,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic [CNT_W-1:0] pkt_cnt
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             last_r;
    logic [CNT_W-1:0] cnt_r;
    logic             drain_s;
    logic             free_s;

    // Handshake decode: a beat leaves when valid meets ready; the slot can accept when empty or draining.
    always_comb begin
        drain_s = 1'b0;
        free_s  = 1'b0;
        if (valid_r) begin
            drain_s = ready;
            free_s  = ready;
        end else begin
            drain_s = 1'b0;
            free_s  = 1'b1;
        end
    end

    // Holding register: a load wins over a drain so load-while-drain keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
            last_r  <= load_last;
        end else if (drain_s) begin
            valid_r <= 1'b0;
        end
    end

    // Packet counter: counts completed last-beat handoffs and wraps freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (drain_s && last_r) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign free    = free_s;
    assign data    = data_r;
    assign valid   = valid_r;
    assign last    = last_r;
    assign pkt_cnt = cnt_r;

endmodule

// File: rtl/demux1_2_8bit_stream.sv
// Packet-aware 1:2 byte stream demultiplexer: the route is latched on the first
// beat of a packet and held until its last beat is accepted.
module demux1_2_8bit_stream
    import demux1_2_8bit_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    output logic             out0_last,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    state_e state_r;
    logic   cur_sel_r;
    logic   tgt_s;
    logic   free0_s;
    logic   free1_s;
    logic   ready_s;
    logic   accept_s;
    logic   load0_s;
    logic   load1_s;

    // Target selection, input backpressure and per-port load strobes.
    always_comb begin
        tgt_s    = pick_tgt(state_r, in_sel, cur_sel_r);
        ready_s  = 1'b0;
        accept_s = 1'b0;
        load0_s  = 1'b0;
        load1_s  = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else if (tgt_s == SEL_OUT1) begin
            ready_s = free1_s;
        end else begin
            ready_s = free0_s;
        end
        accept_s = in_valid & ready_s;
        if (accept_s) begin
            load0_s = (tgt_s == SEL_OUT0);
            load1_s = (tgt_s == SEL_OUT1);
        end else begin
            load0_s = 1'b0;
            load1_s = 1'b0;
        end
    end

    // Packet FSM: opens on a non-last first beat, closes when the last beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cur_sel_r <= SEL_OUT0;
        end else if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!in_last) begin
                        state_r   <= ST_BUSY;
                        cur_sel_r <= tgt_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (in_last) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cur_sel_r <= SEL_OUT0;
                end
            endcase
        end
    end

    assign in_ready = ready_s;

    demux_out_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0_s),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out0_ready),
        .free      (free0_s),
        .data      (out0_data),
        .valid     (out0_valid),
        .last      (out0_last),
        .pkt_cnt   (pkt_cnt0)
    );

    demux_out_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1_s),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out1_ready),
        .free      (free1_s),
        .data      (out1_data),
        .valid     (out1_valid),
        .last      (out1_last),
        .pkt_cnt   (pkt_cnt1)
    );

endmodule
